// File: rtl/class_pop_arbiter_pkg.sv
// Shared encodings for the class-switching stage (read-side arbiter and write-side demux).
package class_pop_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERVE0 = 2'd1,
    ST_SERVE1 = 2'd2
  } state_e;

  localparam logic CLASS0 = 1'b0;
  localparam logic CLASS1 = 1'b1;

endpackage

// File: rtl/class_pop_arbiter_if.sv
// FIFO read-side and destination stream signals of the class pop arbiter.
interface class_pop_arbiter_if #(
  parameter int DATA_SIZE = 10
);
  logic                 fifo0_empty;
  logic                 fifo0_afull;
  logic [DATA_SIZE-1:0] fifo0_data;
  logic                 fifo1_empty;
  logic                 fifo1_afull;
  logic [DATA_SIZE-1:0] fifo1_data;
  logic                 dest_pause;
  logic                 pop0;
  logic                 pop1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 grant;

  modport master (
    input  fifo0_empty, fifo0_afull, fifo0_data,
    input  fifo1_empty, fifo1_afull, fifo1_data,
    input  dest_pause,
    output pop0, pop1, data_out, valid_out, grant
  );

  modport slave (
    output fifo0_empty, fifo0_afull, fifo0_data,
    output fifo1_empty, fifo1_afull, fifo1_data,
    output dest_pause,
    input  pop0, pop1, data_out, valid_out, grant
  );
endinterface

// File: rtl/wrr_credit_counter.sv
// Per-turn pop credit: loadable down-counter with zero and last-pop detect.
module wrr_credit_counter #(
  parameter int WEIGHT_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WEIGHT_W-1:0] load_val,
  input  logic                dec,
  output logic                zero,
  output logic                last
);

  logic [WEIGHT_W-1:0] credit_q, credit_d;

  always_comb begin
    credit_d = credit_q;
    if (load) begin
      credit_d = load_val;
    end else if (dec && (credit_q != '0)) begin
      credit_d = credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= '0;
    end else begin
      credit_q <= credit_d;
    end
  end

  assign zero = (credit_q == '0);
  assign last = (credit_q == WEIGHT_W'(1));

endmodule

// File: rtl/class_pop_arbiter.sv
// Drains the two per-class FIFOs onto one stream with weighted round-robin,
// almost-full boost and downstream pause.
//
//   state     | meaning
//   ST_IDLE   | both FIFOs seen empty, no pops
//   ST_SERVE0 | class-0 turn, pops while credit remains
//   ST_SERVE1 | class-1 turn, pops while credit remains
module class_pop_arbiter
  import class_pop_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT_W  = 3,
  parameter int W0        = 3,
  parameter int W1        = 1
) (
  input  logic                clk,
  input  logic                reset,
  class_pop_arbiter_if.master bus
);

  localparam logic [WEIGHT_W-1:0] W0_C = WEIGHT_W'(W0);
  localparam logic [WEIGHT_W-1:0] W1_C = WEIGHT_W'(W1);

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 pop_d1_q, pop_d1_d;
  logic                 cls_d1_q, cls_d1_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_out_q, valid_out_d;

  logic                 serve1, cur_empty, oth_empty, cur_afull, oth_afull;
  logic                 pop_cur, boost, turn_end;
  logic                 load;
  logic [WEIGHT_W-1:0]  load_val;
  logic                 credit_zero, credit_last;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    load      = 1'b0;
    load_val  = '0;
    serve1    = (state_q == ST_SERVE1);
    cur_empty = serve1 ? bus.fifo1_empty : bus.fifo0_empty;
    oth_empty = serve1 ? bus.fifo0_empty : bus.fifo1_empty;
    cur_afull = serve1 ? bus.fifo1_afull : bus.fifo0_afull;
    oth_afull = serve1 ? bus.fifo0_afull : bus.fifo1_afull;
    pop_cur   = (state_q != ST_IDLE) && !cur_empty && !bus.dest_pause && !credit_zero;
    boost     = oth_afull && !cur_afull;
    // A boost only cuts the turn short once this cycle's pop has gone out.
    turn_end  = (state_q != ST_IDLE) && !bus.dest_pause &&
                (cur_empty || credit_zero || (pop_cur && (credit_last || boost)));

    if (state_q == ST_IDLE) begin
      if (!bus.dest_pause) begin
        if (!bus.fifo0_empty) begin
          state_d  = ST_SERVE0;
          grant_d  = CLASS0;
          load     = 1'b1;
          load_val = W0_C;
        end else if (!bus.fifo1_empty) begin
          state_d  = ST_SERVE1;
          grant_d  = CLASS1;
          load     = 1'b1;
          load_val = W1_C;
        end
      end
    end else if (turn_end) begin
      load = 1'b1;
      if (!oth_empty) begin
        state_d  = serve1 ? ST_SERVE0 : ST_SERVE1;
        grant_d  = serve1 ? CLASS0 : CLASS1;
        load_val = serve1 ? W0_C : W1_C;
      end else if (!cur_empty) begin
        load_val = serve1 ? W1_C : W0_C;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  wrr_credit_counter #(
    .WEIGHT_W (WEIGHT_W)
  ) u_credit (
    .clk      (clk),
    .rst_n    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (pop_cur),
    .zero     (credit_zero),
    .last     (credit_last)
  );

  assign bus.pop0 = reset && pop_cur && !serve1;
  assign bus.pop1 = reset && pop_cur && serve1;

  // FIFO data lags the pop by one cycle, so the class of the pop rides along.
  always_comb begin
    pop_d1_d    = bus.pop0 || bus.pop1;
    cls_d1_d    = bus.pop1;
    valid_out_d = pop_d1_q;
    data_out_d  = data_out_q;
    if (pop_d1_q) begin
      data_out_d = (cls_d1_q == CLASS1) ? bus.fifo1_data : bus.fifo0_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= CLASS0;
      pop_d1_q    <= 1'b0;
      cls_d1_q    <= CLASS0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      pop_d1_q    <= pop_d1_d;
      cls_d1_q    <= cls_d1_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_class_pop_arbiter.sv
// Directed bench for class_pop_arbiter with array-backed FIFO models on both classes.
module tb_class_pop_arbiter;

  localparam int DS = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  class_pop_arbiter_if #(.DATA_SIZE(DS)) bus ();

  class_pop_arbiter #(
    .DATA_SIZE (DS),
    .WEIGHT_W  (3),
    .W0        (3),
    .W1        (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DS-1:0] mem0 [64];
  logic [DS-1:0] mem1 [64];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  int uf_cnt = 0, both_cnt = 0;

  assign bus.fifo0_empty = (rd0 == wr0);
  assign bus.fifo1_empty = (rd1 == wr1);

  always @(posedge clk) begin
    if (!reset) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (bus.pop0 && bus.pop1) both_cnt <= both_cnt + 1;
      if (bus.pop0) begin
        if (rd0 == wr0) uf_cnt <= uf_cnt + 1;
        else begin
          bus.fifo0_data <= mem0[rd0[5:0]];
          rd0 <= rd0 + 1;
        end
      end
      if (bus.pop1) begin
        if (rd1 == wr1) uf_cnt <= uf_cnt + 1;
        else begin
          bus.fifo1_data <= mem1[rd1[5:0]];
          rd1 <= rd1 + 1;
        end
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push0(input int n);
    for (int i = 0; i < n; i++) begin
      mem0[wr0[5:0]] = DS'(wr0);
      wr0++;
    end
  endtask

  task automatic push1(input int n);
    for (int i = 0; i < n; i++) begin
      mem1[wr1[5:0]] = 10'h200 | DS'(wr1);
      wr1++;
    end
  endtask

  int p0, p1, v, g;
  logic [DS-1:0] d;
  int n_pop0 = 0, n_pop1 = 0, n_valid = 0, out_err = 0, grant_err = 0;
  int exp0 = 0, exp1 = 0;

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic cycle();
    @(negedge clk);
    p0 = int'(bus.pop0);
    p1 = int'(bus.pop1);
    v  = int'(bus.valid_out);
    g  = int'(bus.grant);
    d  = bus.data_out;
    n_pop0 += p0;
    n_pop1 += p1;
    if ((p0 + p1) != 0 && g != p1) grant_err++;
    if (v != 0) begin
      n_valid++;
      if (!d[DS-1]) begin
        if (d != DS'(exp0)) out_err++;
        exp0++;
      end else begin
        if (d != (10'h200 | DS'(exp1))) out_err++;
        exp1++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int pseq [40];
  int vseq [40];
  int pat  [8] = '{1, 1, 1, 2, 1, 1, 1, 2};
  int first, last, fi, mism, vgap, b0, b1, bv, bp;

  initial begin
    reset = 1'b0;
    bus.dest_pause  = 1'b0;
    bus.fifo0_afull = 1'b0;
    bus.fifo1_afull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_grant", int'(bus.grant), 0);

    // 1: reset while a pop is in flight and another is being issued
    reset = 1'b1;
    push0(3);
    cycle();
    cycle();
    chk("s1_first_pop", n_pop0, 1);
    chk("s1_pop_live", int'(bus.pop0), 1);
    bv = n_valid;
    reset = 1'b0;
    #1;
    chk("s1_pop_gated", int'(bus.pop0), 0);
    chk("s1_valid", int'(bus.valid_out), 0);
    chk("s1_data", int'(bus.data_out), 0);
    chk("s1_grant", int'(bus.grant), 0);
    cycle();
    cycle();
    reset = 1'b1;
    exp0 = wr0;
    repeat (4) cycle();
    chk("s1_no_emit", n_valid - bv, 0);

    // 2: both classes loaded, 3:1 weighting
    push0(8);
    push1(8);
    b0 = n_pop0;
    b1 = n_pop1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      pseq[i] = p0 + 2 * p1;
      vseq[i] = v;
    end
    first = -1;
    for (int i = 39; i >= 0; i--) if (pseq[i] != 0) first = i;
    chk("s2_first_pop", first, 1);
    fi = (first < 0) ? 0 : first;
    mism = 0;
    vgap = 0;
    for (int k = 0; k < 8; k++) begin
      if (pseq[fi + k] != pat[k]) mism++;
      if (vseq[fi + 2 + k] != 1) vgap++;
    end
    chk("s2_pattern", mism, 0);
    chk("s2_valid_run", vgap, 0);
    chk("s2_pop0_total", n_pop0 - b0, 8);
    chk("s2_pop1_total", n_pop1 - b1, 8);

    // 3: class 1 only, credit reloads every pop
    push1(5);
    b0 = n_pop0;
    b1 = n_pop1;
    bv = n_valid;
    for (int i = 0; i < 12; i++) begin
      cycle();
      pseq[i] = p0 + 2 * p1;
    end
    first = -1;
    last  = -1;
    for (int i = 0; i < 12; i++) begin
      if (pseq[i] != 0 && first < 0) first = i;
      if (pseq[i] != 0) last = i;
    end
    chk("s3_first_pop", first, 1);
    chk("s3_span", last - first, 4);
    chk("s3_pop1", n_pop1 - b1, 5);
    chk("s3_pop0", n_pop0 - b0, 0);
    chk("s3_valid", n_valid - bv, 5);

    // 4: pause mid-turn with two credits left
    push0(6);
    push1(1);
    cycle();
    cycle();
    chk("s4_first_pop0", p0, 1);
    bus.dest_pause = 1'b1;
    bp = n_pop0 + n_pop1;
    bv = n_valid;
    repeat (4) cycle();
    chk("s4_pause_pops", n_pop0 + n_pop1 - bp, 0);
    chk("s4_trailing_valid", n_valid - bv, 1);
    bus.dest_pause = 1'b0;
    cycle();
    chk("s4_rel_pop0_a", p0, 1);
    cycle();
    chk("s4_rel_pop0_b", p0, 1);
    cycle();
    chk("s4_switch_pop1", p1, 1);
    repeat (20) cycle();

    // 5: class-1 almost full boosts the switch
    push0(6);
    push1(2);
    cycle();
    bus.fifo1_afull = 1'b1;
    cycle();
    chk("s5_last_pop0", p0, 1);
    cycle();
    chk("s5_boost_pop1", p1, 1);
    chk("s5_no_pop0", p0, 0);
    bus.fifo1_afull = 1'b0;
    repeat (20) cycle();

    // 6: single class-0 word
    push0(1);
    b0 = n_pop0;
    bv = n_valid;
    cycle();
    cycle();
    chk("s6_pop0", p0, 1);
    repeat (5) cycle();
    chk("s6_pop0_total", n_pop0 - b0, 1);
    chk("s6_valid", n_valid - bv, 1);
    chk("s6_grant", int'(bus.grant), 0);

    chk("underflow", uf_cnt, 0);
    chk("both_pops", both_cnt, 0);
    chk("word_order", out_err, 0);
    chk("grant_track", grant_err, 0);
    chk("drain0", exp0, wr0);
    chk("drain1", exp1, wr1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
